// File: rtl/sb_interconnect.sv
// System-bus interconnect: decodes addr[31:24] against a per-slave ID map and
// forwards one LSU transaction at a time to the selected slave, with a timeout.
module sb_interconnect #(
  parameter int                    N_SLAVES = 4,
  parameter logic [8*N_SLAVES-1:0] SLV_MAP  = 32'h08_06_05_00,
  parameter int                    TIMEOUT  = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     core_req_i,
  input  logic                     core_we_i,
  input  logic [3:0]               core_be_i,
  input  logic [31:0]              core_addr_i,
  input  logic [31:0]              core_wd_i,
  output logic [31:0]              core_rd_o,
  output logic                     core_ready_o,
  output logic                     core_err_o,
  output logic [N_SLAVES-1:0]      slv_req_o,
  output logic                     slv_we_o,
  output logic [3:0]               slv_be_o,
  output logic [31:0]              slv_wd_o,
  output logic [31:0]              slv_addr_o,
  input  logic [32*N_SLAVES-1:0]   slv_rd_i,
  input  logic [N_SLAVES-1:0]      slv_ready_i,
  output logic [31:0]              err_addr_o,
  output logic [7:0]               err_cnt_o
);

  localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int TW = 32;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]    r_state;
  logic [SW-1:0] r_sel;
  logic          r_we;
  logic [3:0]    r_be;
  logic [31:0]   r_addr;
  logic [31:0]   r_wd;
  logic [31:0]   r_rd;
  logic          r_err;
  logic [TW-1:0] r_tcnt;
  logic [31:0]   r_errAddr;
  logic [7:0]    r_errCnt;

  logic          w_hit;
  logic [SW-1:0] w_sel;
  logic          w_selReady;
  logic [31:0]   w_selRd;
  logic          w_timeout;

  // Descending scan so the lowest matching index wins on overlapping IDs.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (core_addr_i[31:24] == SLV_MAP[8*i +: 8]) begin
        w_hit = 1'b1;
        w_sel = SW'(i);
      end
    end
  end

  always_comb begin
    w_selReady = 1'b0;
    w_selRd    = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (r_sel == SW'(i)) begin
        w_selReady = slv_ready_i[i];
        w_selRd    = slv_rd_i[32*i +: 32];
      end
    end
  end

  assign w_timeout = (TIMEOUT != 0) && (r_tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_addr    <= '0;
      r_wd      <= '0;
      r_rd      <= '0;
      r_err     <= 1'b0;
      r_tcnt    <= '0;
      r_errAddr <= '0;
      r_errCnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (core_req_i) begin
            r_we   <= core_we_i;
            r_be   <= core_be_i;
            r_addr <= core_addr_i;
            r_wd   <= core_wd_i;
            r_tcnt <= '0;
            if (w_hit) begin
              r_sel   <= w_sel;
              r_state <= S_ACCESS;
            end else begin
              r_err     <= 1'b1;
              r_errAddr <= core_addr_i;
              if (r_errCnt != 8'hFF) r_errCnt <= r_errCnt + 8'd1;
              r_state   <= S_RESP;
            end
          end
        end
        S_ACCESS: begin
          // Ready is tested first so a ready on the final allowed cycle succeeds.
          if (w_selReady) begin
            r_rd    <= w_selRd;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_rd      <= '0;
            r_err     <= 1'b1;
            r_errAddr <= r_addr;
            if (r_errCnt != 8'hFF) r_errCnt <= r_errCnt + 8'd1;
            r_state   <= S_RESP;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    slv_req_o = '0;
    if (r_state == S_ACCESS) begin
      for (int i = 0; i < N_SLAVES; i++) begin
        if (r_sel == SW'(i)) slv_req_o[i] = 1'b1;
      end
    end
  end

  assign core_ready_o = (r_state == S_RESP);
  assign core_err_o   = (r_state == S_RESP) && r_err;
  assign core_rd_o    = r_rd;
  assign slv_we_o     = r_we;
  assign slv_be_o     = r_be;
  assign slv_wd_o     = r_wd;
  assign slv_addr_o   = {8'd0, r_addr[23:0]};
  assign err_addr_o   = r_errAddr;
  assign err_cnt_o    = r_errCnt;

endmodule

// File: doc/sb_interconnect.md
# sb_interconnect

Parametrised system-bus interconnect between the LSU memory port and N peripheral slaves (RAM, UART RX/TX, timer, future devices). It decodes `core_addr_i[31:24]` against a per-slave ID map and forwards one transaction at a time with a req/ready handshake. It returns registered read data and flags unmapped or timed-out accesses as bus errors. It replaces the fixed one-hot decode and read mux in the top level with a single block that tolerates slow slaves.

## Interface
- `N_SLAVES`, 4 — number of slave channels, 1..16.
- `SLV_MAP`, 32'h08_06_05_00 — packed 8-bit IDs; slave i owns `addr[31:24] == SLV_MAP[8*i +: 8]`. Default: 0=RAM 0x00, 1=UART RX 0x05, 2=UART TX 0x06, 3=timer 0x08.
- `TIMEOUT`, 255 — maximum ACCESS cycles without `ready`; 0 disables the timeout.
- `clk_i` in 1 — system clock; the only clock.
- `rst_i` in 1 — reset, synchronous, active-high.
- `core_req_i` in 1 — master request; held until `core_ready_o`.
- `core_we_i` in 1 — write enable.
- `core_be_i` in 4 — byte enables.
- `core_addr_i` in 32 — byte address.
- `core_wd_i` in 32 — write data.
- `core_rd_o` out 32 — read data; registered, held until the next response.
- `core_ready_o` out 1 — one-cycle response strobe.
- `core_err_o` out 1 — error qualifier, valid with `core_ready_o`.
- `slv_req_o` out N_SLAVES — per-slave request, at most one bit high.
- `slv_we_o` out 1, `slv_be_o` out 4, `slv_wd_o` out 32 — latched transaction fields, broadcast to all slaves.
- `slv_addr_o` out 32 — `{8'd0, latched_addr[23:0]}`.
- `slv_rd_i` in 32*N_SLAVES — slave i read data at `[32*i +: 32]`.
- `slv_ready_i` in N_SLAVES — slave i completion.
- `err_addr_o` out 32 — address of the most recent errored transaction.
- `err_cnt_o` out 8 — saturating error count.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - On `core_req_i`: latch `we`, `be`, `addr`, `wd` and decode.
  - If any slave matches, select the lowest matching index and go to ACCESS with `tcnt` = 0.
  - If no slave matches, go to RESP with `err` = 1. No slave is requested.
- **ACCESS**
  - `slv_req_o[sel]` = 1. Address, data, `we` and `be` outputs are stable throughout.
  - On `slv_ready_i[sel]`:
    - Capture `slv_rd_i[sel]` into `core_rd_o`; for writes capture the value anyway.
    - Set `err` = 0 and go to RESP.
  - `slv_ready_i` bits of unselected slaves are ignored.
  - Otherwise `tcnt` increments each cycle.
  - If `TIMEOUT` != 0 and `tcnt == TIMEOUT-1` without ready, go to RESP with `err` = 1, `core_rd_o` = 0, and drop the request.
- **RESP**
  - `core_ready_o` = 1 and `core_err_o` = `err` for exactly one cycle, then go to IDLE.
  - `core_req_i` is ignored in RESP. The master deasserts it or re-presents it for the next access, accepted in IDLE.
- **Error record** (on entry to RESP with `err` = 1):
  - `err_addr_o` takes the full 32-bit latched address.
  - `err_cnt_o` increments and saturates at 255.
- **Reset**
  - At any state, including mid-ACCESS, the next edge forces IDLE.
  - All outputs go to 0; `err_addr_o` = 0 and `err_cnt_o` = 0.
  - An in-flight transaction is abandoned with no response.

## Timing
- Request sampled in IDLE at edge 0.
- `slv_req_o` high from cycle 1.
- Slave ready asserted in cycle k ≥ 1 makes `core_ready_o` high in cycle k+1.
- Minimum latency is 2 cycles (zero-wait slave).
- Unmapped access: `core_ready_o` in cycle 1, `err` = 1.
- Timeout: `slv_req_o` is high for exactly `TIMEOUT` cycles; `core_ready_o` + `core_err_o` follow in the next cycle.
- Back-to-back: with `core_req_i` held continuously, the next transaction is sampled in the IDLE cycle after RESP, i.e. one transaction per 3 + wait cycles.
- Ready arriving in the same cycle that `tcnt` hits the limit counts as success; ready wins.
- A late ready arriving after a timeout, in RESP or IDLE, is ignored.

## Test plan
- **Zero-wait read:** read of 0x0000_0010 with RAM (slave 0) ready in the first ACCESS cycle returning 0x1234_5678.
  - `slv_req_o` = 4'b0001 for 1 cycle.
  - `slv_addr_o` = 0x0000_0010.
  - `core_ready_o` at cycle 2 with `core_rd_o` = 0x1234_5678 and `err` = 0.
- **Wait-state write:** write 0xA5 to UART TX 0x0600_0000 with `be` = 4'b0001; slave 2 holds ready low for 3 cycles.
  - `slv_req_o` = 4'b0100 for 4 cycles with `slv_wd_o` stable.
  - `core_ready_o` at cycle 5.
- **Unmapped access:** access 0x0300_0004.
  - No `slv_req_o`.
  - `core_ready_o` + `core_err_o` at cycle 1.
  - `err_addr_o` = 0x0300_0004 and `err_cnt_o` = 1.
- **Timeout:** `TIMEOUT` = 4, timer slave never ready.
  - `slv_req_o[3]` high for exactly 4 cycles.
  - Error response with `core_rd_o` = 0 and `err_cnt_o` incremented.
  - A late `slv_ready_i[3]` afterwards produces no response.
- **Reset and saturation:**
  - `rst_i` asserted mid-ACCESS: all outputs are 0 next cycle, and a fresh read completes normally afterwards.
  - 300 unmapped accesses leave `err_cnt_o` = 255.
- **Overlapping map:** `SLV_MAP` with slaves 1 and 2 both mapped to 0x05. An access to 0x0500_0000 selects slave 1 only.
